// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the segment scan controller and its host/segment decoder.
// The host loads BCD values and controls blanking; the controller returns
// the current digit selection, its decoder key and status flags.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_en;
  logic [1:0]  sel;
  logic [3:0]  key;
  logic        blank;
  logic        upd_done;
  logic        bcd_err;

  modport master (
    output load, bcd_in, blank_en,
    input  sel, key, blank, upd_done, bcd_err
  );

  modport slave (
    input  load, bcd_in, blank_en,
    output sel, key, blank, upd_done, bcd_err
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// A prescaler steps the digit index; loaded values are shadowed and only
// promoted to the displayed register on a frame boundary (tick at sel==3),
// so a scanned frame never mixes old and new digits.
module seg_scan_ctrl #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned SCAN_HZ  = 1000
) (
  input logic          clk,
  input logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned DIV = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          upd_done_q, upd_done_d;

  logic          tick;
  logic          frame;
  logic [3:0]    nib [4];
  logic [3:0]    nib_sel;

  assign tick  = (cnt_q == CNT_MAX);
  assign frame = tick && (sel_q == 2'd3);

  // Prescaler and digit index advance.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    sel_d = tick ? sel_q + 2'd1 : sel_q;
  end

  // Shadow/pending bookkeeping; a load coinciding with a frame boundary
  // bypasses the shadow and becomes active at that same boundary.
  always_comb begin
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    upd_done_d = 1'b0;
    if (frame) begin
      if (bus.load) begin
        active_d   = bus.bcd_in;
        shadow_d   = bus.bcd_in;
        pending_d  = 1'b0;
        upd_done_d = 1'b1;
      end else if (pending_q) begin
        active_d   = shadow_q;
        pending_d  = 1'b0;
        upd_done_d = 1'b1;
      end
    end else if (bus.load) begin
      shadow_d  = bus.bcd_in;
      pending_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      active_q   <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      upd_done_q <= upd_done_d;
    end
  end

  // Digit decode, error flag and leading-zero blanking from registered state.
  always_comb begin
    nib[0]  = active_q[3:0];
    nib[1]  = active_q[7:4];
    nib[2]  = active_q[11:8];
    nib[3]  = active_q[15:12];
    nib_sel = nib[sel_q];

    bus.key     = (nib_sel > 4'd9) ? 4'd10 : nib_sel;
    bus.bcd_err = (nib[0] > 4'd9) || (nib[1] > 4'd9) ||
                  (nib[2] > 4'd9) || (nib[3] > 4'd9);

    bus.blank = 1'b0;
    if (bus.blank_en) begin
      case (sel_q)
        2'd3:    bus.blank = (nib[3] == 4'd0);
        2'd2:    bus.blank = (nib[3] == 4'd0) && (nib[2] == 4'd0);
        2'd1:    bus.blank = (nib[3] == 4'd0) && (nib[2] == 4'd0) &&
                             (nib[1] == 4'd0);
        default: bus.blank = 1'b0;
      endcase
    end
  end

  assign bus.sel      = sel_q;
  assign bus.upd_done = upd_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4.
// The bench keeps its own cycle count since reset release; the expected
// digit index is (cyc/4)%4 and the phase within a digit is cyc%4.
module tb_seg_scan_ctrl;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   pulses;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_FREQ (40),
    .SCAN_HZ  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sampling at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.upd_done === 1'b1) pulses++;
  endtask

  // Advance to the sample where expected sel==s and phase==p.
  task automatic goto(input int s, input int p);
    for (int k = 0; k < 32; k++) begin
      if (((cyc / 4) % 4) == s && (cyc % 4) == p) break;
      step();
    end
  endtask

  // One-cycle load pulse; returns one sample later.
  task automatic do_load(input logic [15:0] v);
    bus.bcd_in = v;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    pulses   = 0;
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.bcd_in = 16'h0000;
    bus.blank_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sel",  16'(bus.sel), 16'd0);
    chk("rst_key",  16'(bus.key), 16'd0);
    chk("rst_blank", 16'(bus.blank), 16'd0);
    chk("rst_upd",  16'(bus.upd_done), 16'd0);
    chk("rst_err",  16'(bus.bcd_err), 16'd0);

    // Free-running scan with no load
    bus.blank_en = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 17; i++) begin
      chk("scan_sel", 16'(bus.sel), 16'((cyc / 4) % 4));
      chk("scan_key", 16'(bus.key), 16'd0);
      step();
    end

    // Load 1234 during sel=1: held until the 3->0 boundary
    goto(1, 1);
    do_load(16'h1234);
    pulses = 0;
    while (!(((cyc / 4) % 4) == 3 && (cyc % 4) == 3)) begin
      chk("hold_key", 16'(bus.key), 16'd0);
      step();
    end
    chk("hold_pulses", 16'(pulses), 16'd0);
    step();
    chk("upd_1234", 16'(bus.upd_done), 16'd1);
    chk("key_s0", 16'(bus.key), 16'd4);
    step();
    chk("upd_clr", 16'(bus.upd_done), 16'd0);
    goto(1, 0); chk("key_s1", 16'(bus.key), 16'd3);
    goto(2, 0); chk("key_s2", 16'(bus.key), 16'd2);
    goto(3, 0); chk("key_s3", 16'(bus.key), 16'd1);

    // Overwrite before boundary: latest wins, single pulse
    goto(0, 1);
    do_load(16'h1111);
    goto(1, 1);
    chk("ovr_hold", 16'(bus.key), 16'd3);
    goto(2, 0);
    do_load(16'h2222);
    pulses = 0;
    goto(3, 3);
    chk("ovr_nopulse", 16'(pulses), 16'd0);
    step();
    chk("ovr_upd", 16'(bus.upd_done), 16'd1);
    chk("ovr_key0", 16'(bus.key), 16'd2);
    pulses = 0;
    goto(1, 0);
    chk("ovr_key1", 16'(bus.key), 16'd2);
    goto(3, 3);
    chk("ovr_onepulse", 16'(pulses), 16'd0);

    // Load in the boundary cycle applies at that boundary
    do_load(16'h0050);
    chk("bnd_upd", 16'(bus.upd_done), 16'd1);
    chk("bnd_key0", 16'(bus.key), 16'd0);
    chk("bnd_err", 16'(bus.bcd_err), 16'd0);

    // Blanking with 0050
    bus.blank_en = 1'b1;
    #1;
    chk("blk50_s0", 16'(bus.blank), 16'd0);
    goto(1, 0); chk("blk50_s1", 16'(bus.blank), 16'd0);
    chk("key50_s1", 16'(bus.key), 16'd5);
    goto(2, 0); chk("blk50_s2", 16'(bus.blank), 16'd1);
    goto(3, 0); chk("blk50_s3", 16'(bus.blank), 16'd1);
    bus.blank_en = 1'b0;
    #1;
    chk("blk_off_now", 16'(bus.blank), 16'd0);

    // Blanking with 0000, then disabled
    goto(3, 3);
    do_load(16'h0000);
    bus.blank_en = 1'b1;
    #1;
    chk("blk0_s0", 16'(bus.blank), 16'd0);
    goto(1, 0); chk("blk0_s1", 16'(bus.blank), 16'd1);
    goto(2, 0); chk("blk0_s2", 16'(bus.blank), 16'd1);
    goto(3, 0); chk("blk0_s3", 16'(bus.blank), 16'd1);
    bus.blank_en = 1'b0;
    goto(0, 0); chk("noblk_s0", 16'(bus.blank), 16'd0);
    goto(1, 0); chk("noblk_s1", 16'(bus.blank), 16'd0);
    goto(2, 0); chk("noblk_s2", 16'(bus.blank), 16'd0);
    goto(3, 0); chk("noblk_s3", 16'(bus.blank), 16'd0);

    // Invalid nibble
    goto(3, 3);
    do_load(16'h00A3);
    bus.blank_en = 1'b1;
    #1;
    chk("err_key0", 16'(bus.key), 16'd3);
    chk("err_flag", 16'(bus.bcd_err), 16'd1);
    goto(1, 0);
    chk("err_key1", 16'(bus.key), 16'd10);
    chk("err_blk1", 16'(bus.blank), 16'd0);
    goto(2, 0);
    chk("err_blk2", 16'(bus.blank), 16'd1);
    chk("err_key2", 16'(bus.key), 16'd0);

    // Reset mid-frame with a pending load
    goto(0, 1);
    do_load(16'h9876);
    goto(1, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 16'(bus.sel), 16'd0);
    chk("mid_rst_key", 16'(bus.key), 16'd0);
    chk("mid_rst_blank", 16'(bus.blank), 16'd0);
    chk("mid_rst_upd", 16'(bus.upd_done), 16'd0);
    chk("mid_rst_err", 16'(bus.bcd_err), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      chk("post_rst_sel", 16'(bus.sel), 16'((cyc / 4) % 4));
      chk("post_rst_key", 16'(bus.key), 16'd0);
      step();
    end
    chk("post_rst_pulses", 16'(pulses), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit scan rate in Hz; DIV = CLK_FREQ/SCAN_HZ SHALL be an integer of at least 2.
REQ-003 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  single-cycle request to display bcd_in.
REQ-006 bcd_in  input  16  four BCD digits; [3:0] least significant digit, [15:12] most significant digit.
REQ-007 blank_en  input  1  1 enables leading-zero blanking.
REQ-008 sel  output  2  digit index driven to the segment decoder; 0 selects the least significant digit.
REQ-009 key  output  4  code for the selected digit, driven to the segment decoder.
REQ-010 blank  output  1  1 means the top level SHALL force the selected digit off.
REQ-011 upd_done  output  1  one-cycle pulse when a loaded value becomes the displayed value.
REQ-012 bcd_err  output  1  1 while the displayed value contains any nibble greater than 9.

Function
REQ-013 Prescaler cnt SHALL count 0..DIV-1 and wrap; tick SHALL be asserted in the cycle where cnt == DIV-1.
REQ-014 On tick, sel SHALL increment modulo 4 (3 -> 0); otherwise sel SHALL hold.
REQ-015 A load SHALL capture bcd_in into a shadow register and set a pending flag.
- If load repeats while pending, the latest value SHALL win.
REQ-016 A frame boundary is a tick with sel == 3.
- At a frame boundary with pending=1, the shadow SHALL transfer to the active register and pending SHALL clear.
REQ-017 If load and a frame boundary occur in the same cycle, bcd_in SHALL go directly to active and pending SHALL end at 0.
REQ-018 upd_done SHALL be registered and pulse high for exactly one cycle, in the cycle after active changes.
- It SHALL also pulse when the new value equals the old one.
REQ-019 The active register SHALL never change except at a frame boundary, so a frame is never torn.
REQ-020 key SHALL be a combinational function of the registered sel and active registers.
- key SHALL equal the selected nibble N.
- If N > 9, key SHALL be 4'd10 (error glyph).
REQ-021 bcd_err SHALL be a combinational OR over the four active nibbles of (nibble > 9).
REQ-022 Blanking, applied only when blank_en=1; digit 0 SHALL never blank:
- sel=3 blanks if nibble3==0.
- sel=2 blanks if nibble3==0 and nibble2==0.
- sel=1 blanks if nibbles 3, 2 and 1 are all 0.
REQ-023 An invalid nibble (>9) SHALL count as nonzero for blanking.
REQ-024 blank_en SHALL take effect immediately; it is not shadowed.

Reset
REQ-025 rst_n low SHALL immediately clear cnt, sel, active, shadow, pending and upd_done to 0.
- Outputs during reset: sel=0, key=0, blank=0, upd_done=0, bcd_err=0.
REQ-026 Reset asserted mid-frame or while pending SHALL discard the pending value.
- After release, scanning SHALL restart at sel=0 with cnt=0.

Verification
REQ-027 Bench parameters: CLK_FREQ=40, SCAN_HZ=10 (DIV=4).
REQ-028 Scan: after reset release, with no load -> sel steps 0,1,2,3,0 every 4 clocks; key=0 throughout.
REQ-029 Load/frame: load bcd_in=16'h1234 while sel=1 -> active unchanged until the sel 3->0 boundary.
- upd_done pulses once, 1 cycle later.
- key then reads 4,3,2,1 for sel=0..3.
REQ-030 Overwrite and simultaneous events:
- load 16'h1111, then load 16'h2222 before the boundary -> 2222 is displayed with one upd_done.
- load in the boundary cycle -> the value is applied at that boundary.
REQ-031 Blanking: active=16'h0050, blank_en=1 -> blank=0,0,1,1 for sel=0..3.
- active=16'h0000 -> blank=0,1,1,1.
- With blank_en=0, all blank=0.
REQ-032 Error and reset:
- load 16'h00A3 -> key=10 at sel=1; bcd_err=1; blank=0 at sel=1.
- Assert rst_n low mid-frame with a pending load -> all outputs 0; the pending value is never displayed.
